// File: rtl/sdft_bin_pipe.sv
// Sliding-DFT bin update: Xk_new = W_k * (Xk_prev + x_new - x_old) over a four-stage
// ce-gated pipeline, with bypass/clear modes, round-half-up, saturation and a sticky counter.
module sdft_bin_pipe #(
  parameter  int WORD_WIDTH   = 16,
  parameter  int FFT_SIZE     = 512,
  parameter  int SIDE_WIDTH   = 2,
  parameter  int TW_FRAC      = WORD_WIDTH - 2,
  parameter  int SATCNT_WIDTH = 16,
  localparam int IDX_W        = $clog2(FFT_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_ce,
  input  logic                      i_valid,
  input  logic [WORD_WIDTH-1:0]     i_sample_new,
  input  logic [WORD_WIDTH-1:0]     i_sample_old,
  input  logic [2*WORD_WIDTH-1:0]   i_twiddle,
  input  logic [2*WORD_WIDTH-1:0]   i_xk_prev,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [SIDE_WIDTH-1:0]     i_side,
  input  logic                      i_bypass,
  input  logic                      i_clr,
  input  logic                      i_sat_clear,
  output logic                      o_valid,
  output logic [2*WORD_WIDTH-1:0]   o_xk,
  output logic [IDX_W-1:0]          o_idx,
  output logic [SIDE_WIDTH-1:0]     o_side,
  output logic                      o_sat,
  output logic [SATCNT_WIDTH-1:0]   o_sat_count
);
  // Handshake: a beat transfers on a rising edge only when valid=1 and i_ce=1, on both
  // the input and output side; with i_ce=0 every register (including o_valid) holds.

  localparam int W  = WORD_WIDTH;
  localparam int AW = W + 2;
  localparam int PW = 2 * W + 2;
  localparam int CW = 2 * W + 3;
  localparam int RW = 2 * W + 4;

  localparam logic signed [RW-1:0] MAX_V = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = ~MAX_V;
  localparam logic signed [RW-1:0] RND   = RW'(1) << (TW_FRAC - 1);

  // Returns {clipped, value}.
  function automatic logic [W:0] clamp(input logic signed [RW-1:0] v);
    if (v > MAX_V) return {1'b1, MAX_V[W-1:0]};
    if (v < MIN_V) return {1'b1, MIN_V[W-1:0]};
    return {1'b0, v[W-1:0]};
  endfunction

  logic signed [W-1:0] xin_re, xin_im, tw_in_re, tw_in_im, s_new, s_old;
  assign xin_re   = i_xk_prev[2*W-1:W];
  assign xin_im   = i_xk_prev[W-1:0];
  assign tw_in_re = i_twiddle[2*W-1:W];
  assign tw_in_im = i_twiddle[W-1:0];
  assign s_new    = i_sample_new;
  assign s_old    = i_sample_old;

  logic signed [AW-1:0] sum_re;
  assign sum_re = AW'(xin_re) + AW'(s_new) - AW'(s_old);

  logic [3:1]            v_q, byp_q, clr_q;
  logic [IDX_W-1:0]      idx_q  [1:3];
  logic [SIDE_WIDTH-1:0] side_q [1:3];
  logic signed [AW-1:0]  a_re_q [1:3];
  logic signed [AW-1:0]  a_im_q [1:3];
  logic signed [W-1:0]   tw_re_q, tw_im_q;
  logic signed [PW-1:0]  m_rr_q, m_ii_q, m_ri_q, m_ir_q;
  logic signed [CW-1:0]  p_re_q, p_im_q;

  logic signed [RW-1:0] rnd_re, rnd_im, src_re, src_im;
  logic [W:0]           sat_re, sat_im;
  logic                 sat_next;

  always_comb begin
    rnd_re   = (RW'(p_re_q) + RND) >>> TW_FRAC;
    rnd_im   = (RW'(p_im_q) + RND) >>> TW_FRAC;
    // Bypass rides the S1 sum through the pipe so latency is identical in both modes.
    src_re   = byp_q[3] ? RW'(a_re_q[3]) : rnd_re;
    src_im   = byp_q[3] ? RW'(a_im_q[3]) : rnd_im;
    sat_re   = clamp(src_re);
    sat_im   = clamp(src_im);
    sat_next = v_q[3] & ~clr_q[3] & (sat_re[W] | sat_im[W]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      byp_q   <= '0;
      clr_q   <= '0;
      for (int i = 1; i <= 3; i++) begin
        idx_q[i]  <= '0;
        side_q[i] <= '0;
        a_re_q[i] <= '0;
        a_im_q[i] <= '0;
      end
      tw_re_q     <= '0;
      tw_im_q     <= '0;
      m_rr_q      <= '0;
      m_ii_q      <= '0;
      m_ri_q      <= '0;
      m_ir_q      <= '0;
      p_re_q      <= '0;
      p_im_q      <= '0;
      o_valid     <= 1'b0;
      o_xk        <= '0;
      o_idx       <= '0;
      o_side      <= '0;
      o_sat       <= 1'b0;
      o_sat_count <= '0;
    end else if (i_ce) begin
      v_q   <= {v_q[2:1], i_valid};
      byp_q <= {byp_q[2:1], i_bypass};
      clr_q <= {clr_q[2:1], i_clr};
      idx_q[1]  <= i_idx;
      side_q[1] <= i_side;
      a_re_q[1] <= sum_re;
      a_im_q[1] <= AW'(xin_im);
      tw_re_q   <= tw_in_re;
      tw_im_q   <= tw_in_im;
      for (int i = 2; i <= 3; i++) begin
        idx_q[i]  <= idx_q[i-1];
        side_q[i] <= side_q[i-1];
        a_re_q[i] <= a_re_q[i-1];
        a_im_q[i] <= a_im_q[i-1];
      end
      m_rr_q <= PW'(a_re_q[1]) * PW'(tw_re_q);
      m_ii_q <= PW'(a_im_q[1]) * PW'(tw_im_q);
      m_ri_q <= PW'(a_re_q[1]) * PW'(tw_im_q);
      m_ir_q <= PW'(a_im_q[1]) * PW'(tw_re_q);
      p_re_q <= CW'(m_rr_q) - CW'(m_ii_q);
      p_im_q <= CW'(m_ri_q) + CW'(m_ir_q);
      o_valid <= v_q[3];
      o_idx   <= idx_q[3];
      o_side  <= side_q[3];
      o_xk    <= clr_q[3] ? '0 : {sat_re[W-1:0], sat_im[W-1:0]};
      o_sat   <= sat_next;
      if (i_sat_clear)
        o_sat_count <= SATCNT_WIDTH'(sat_next);
      else if (sat_next && !(&o_sat_count))
        o_sat_count <= o_sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdft_bin_pipe.sv
// Directed bench for sdft_bin_pipe: driver tasks push hand-computed results into a queue,
// an independent negedge monitor pops and compares whenever a beat leaves the pipeline.
module tb_sdft_bin_pipe;
  localparam int W    = 16;
  localparam int IDX_W = 9;
  localparam int SW   = 2;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, i_ce, i_valid, i_bypass, i_clr, i_sat_clear;
  logic [W-1:0]     i_sample_new, i_sample_old;
  logic [2*W-1:0]   i_twiddle, i_xk_prev;
  logic [IDX_W-1:0] i_idx;
  logic [SW-1:0]    i_side;
  logic             o_valid, o_sat;
  logic [2*W-1:0]   o_xk;
  logic [IDX_W-1:0] o_idx;
  logic [SW-1:0]    o_side;
  logic [CNTW-1:0]  o_sat_count;

  sdft_bin_pipe dut (
    .clk(clk), .reset(reset), .i_ce(i_ce), .i_valid(i_valid),
    .i_sample_new(i_sample_new), .i_sample_old(i_sample_old),
    .i_twiddle(i_twiddle), .i_xk_prev(i_xk_prev), .i_idx(i_idx), .i_side(i_side),
    .i_bypass(i_bypass), .i_clr(i_clr), .i_sat_clear(i_sat_clear),
    .o_valid(o_valid), .o_xk(o_xk), .o_idx(o_idx), .o_side(o_side),
    .o_sat(o_sat), .o_sat_count(o_sat_count)
  );

  typedef struct {
    logic [2*W-1:0]   xk;
    logic [IDX_W-1:0] idx;
    logic [SW-1:0]    side;
    logic             sat;
    logic [CNTW-1:0]  cnt;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  exp_t e, last_exp;
  logic have_last = 1'b0;
  int   tests = 0, fails = 0, ce_edges = 0;
  logic ce_at_edge = 1'b0, rst_at_edge = 1'b0;

  function automatic logic [2*W-1:0] cx(input int re, input int im);
    logic [W-1:0] r, m;
    r = re[W-1:0];
    m = im[W-1:0];
    return {r, m};
  endfunction

  always @(posedge clk) begin
    ce_at_edge  = i_ce;
    rst_at_edge = reset;
    if (i_ce && !reset) ce_edges++;
  end

  always @(negedge clk) begin
    if (rst_at_edge) begin
      exp_q.delete();
      have_last = 1'b0;
      tests++;
      if (o_valid !== 1'b0 || o_sat !== 1'b0 || o_xk !== '0 || o_sat_count !== '0) begin
        fails++;
        $display("FAIL reset_state: got valid=%0b sat=%0b xk=%h cnt=%0d, want all 0",
                 o_valid, o_sat, o_xk, o_sat_count);
      end
    end else if (ce_at_edge) begin
      while (exp_q.size() > 0 && exp_q[0].due < ce_edges) begin
        tests++;
        fails++;
        $display("FAIL missing_beat: idx=%0d due at ce edge %0d, now %0d",
                 exp_q[0].idx, exp_q[0].due, ce_edges);
        void'(exp_q.pop_front());
      end
      if (o_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got idx=%0d xk=%h, want no output", o_idx, o_xk);
          have_last = 1'b0;
        end else begin
          e = exp_q.pop_front();
          if (o_xk !== e.xk || o_idx !== e.idx || o_side !== e.side ||
              o_sat !== e.sat || o_sat_count !== e.cnt || e.due != ce_edges) begin
            fails++;
            $display("FAIL beat_idx%0d: got xk=%h idx=%0d side=%0d sat=%0b cnt=%0d edge=%0d, want xk=%h idx=%0d side=%0d sat=%0b cnt=%0d edge=%0d",
                     e.idx, o_xk, o_idx, o_side, o_sat, o_sat_count, ce_edges,
                     e.xk, e.idx, e.side, e.sat, e.cnt, e.due);
          end
          last_exp  = e;
          have_last = 1'b1;
        end
      end else begin
        tests++;
        have_last = 1'b0;
        if (o_sat !== 1'b0) begin
          fails++;
          $display("FAIL invalid_sat: got o_sat=%0b with o_valid=0, want 0", o_sat);
        end
      end
    end else if (o_valid) begin
      tests++;
      if (!have_last || o_xk !== last_exp.xk || o_idx !== last_exp.idx) begin
        fails++;
        $display("FAIL stall_hold: got xk=%h idx=%0d, want xk=%h idx=%0d held",
                 o_xk, o_idx, last_exp.xk, last_exp.idx);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_ce    = 1'b1;
    i_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic stall(input int n);
    i_ce    = 1'b0;
    i_valid = 1'b0;
    repeat (n) tick();
    i_ce = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    i_ce  = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    i_ce  = 1'b1;
  endtask

  task automatic sat_clear_cycle();
    i_ce        = 1'b1;
    i_valid     = 1'b0;
    i_sat_clear = 1'b1;
    tick();
    i_sat_clear = 1'b0;
  endtask

  task automatic beat(input int xr, input int xi, input int nw, input int od,
                      input int tr, input int ti, input int idx,
                      input logic byp, input logic clr, input logic vld,
                      input int er, input int ei, input logic esat, input int ecnt);
    exp_t x;
    i_ce         = 1'b1;
    i_valid      = vld;
    i_xk_prev    = cx(xr, xi);
    i_sample_new = nw[W-1:0];
    i_sample_old = od[W-1:0];
    i_twiddle    = cx(tr, ti);
    i_idx        = idx[IDX_W-1:0];
    i_side       = idx[SW-1:0];
    i_bypass     = byp;
    i_clr        = clr;
    if (vld) begin
      x.xk   = cx(er, ei);
      x.idx  = idx[IDX_W-1:0];
      x.side = idx[SW-1:0];
      x.sat  = esat;
      x.cnt  = ecnt[CNTW-1:0];
      x.due  = ce_edges + 4;
      exp_q.push_back(x);
    end
    tick();
    i_valid  = 1'b0;
    i_bypass = 1'b0;
    i_clr    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_ce = 1'b1; i_valid = 1'b0; i_bypass = 1'b0; i_clr = 1'b0;
    i_sat_clear = 1'b0; i_sample_new = '0; i_sample_old = '0; i_twiddle = '0;
    i_xk_prev = '0; i_idx = '0; i_side = '0;
    tick(); tick();
    reset = 1'b0;
    idle(2);

    // identity twiddle, then j twiddle back-to-back idx 0..7
    beat(100, 50, 30, 10, 16384, 0, 1, 0, 0, 1, 120, 50, 0, 0);
    idle(5);
    for (int i = 0; i < 8; i++)
      beat(100, 50, 30, 10, 0, 16384, i, 0, 0, 1, -50, 120, 0, 0);
    idle(5);

    // rounding, including exact halves
    beat(3, -3, 0, 0, 8192, 0, 40, 0, 0, 1, 2, -1, 0, 0);
    beat(1, -1, 0, 0, 8192, 0, 41, 0, 0, 1, 1, 0, 0, 0);
    // invalid saturating beat must not flag or count
    beat(32767, 0, 100, 0, 16384, 0, 42, 0, 0, 0, 0, 0, 0, 0);
    idle(5);

    // saturation: positive real, negative real, positive imag
    beat(32767, 0, 100, 0, 16384, 0, 50, 0, 0, 1, 32767, 0, 1, 1);
    beat(-32768, 0, 0, 100, 16384, 0, 51, 0, 0, 1, -32768, 0, 1, 2);
    beat(32767, 0, 100, 0, 0, 16384, 52, 0, 0, 1, 0, 32767, 1, 3);
    idle(5);
    // clear coinciding with a saturated load, then clear alone
    beat(32767, 0, 100, 0, 16384, 0, 53, 0, 0, 1, 32767, 0, 1, 1);
    idle(2);
    sat_clear_cycle();
    idle(3);
    sat_clear_cycle();
    beat(100, 50, 30, 10, 16384, 0, 54, 0, 0, 1, 120, 50, 0, 0);
    idle(5);

    // modes
    beat(10, -5, 7, 2, 1234, -777, 60, 1, 0, 1, 15, -5, 0, 0);
    beat(32767, 0, 100, 0, 16384, 0, 61, 1, 1, 1, 0, 0, 0, 0);
    beat(32767, 5, 100, 0, -999, 321, 62, 1, 0, 1, 32767, 5, 1, 1);
    idle(5);

    // stall mid-flight with a valid output held
    for (int i = 0; i < 3; i++)
      beat(1000 + i, -i, 0, 0, 16384, 0, 20 + i, 0, 0, 1, 1000 + i, -i, 0, 1);
    idle(1);
    stall(3);
    idle(5);

    // reset mid-flight (ce low, reset must still win)
    beat(200, 0, 0, 0, 16384, 0, 30, 0, 0, 1, 200, 0, 0, 1);
    beat(201, 0, 0, 0, 16384, 0, 31, 0, 0, 1, 201, 0, 0, 1);
    idle(1);
    do_reset(1);
    idle(8);
    beat(100, 50, 30, 10, 16384, 0, 70, 0, 0, 1, 120, 50, 0, 0);
    idle(6);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d beats outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdft_bin_pipe.md
# sdft_bin_pipe

Parametrised sliding-DFT bin-update pipeline for the STFT compute path. Each accepted transaction computes Xk_new = W_k · (Xk_prev + x_new − x_old), with rounding and saturation. Indices and sideband bits travel through the pipeline aligned with their data. Compared with the earlier fixed compute unit, it adds:
- a real valid/clock-enable pipeline and synchronous reset;
- internal sample differencing at widened precision;
- bypass and clear modes;
- saturation flagging with a sticky saturation counter.

It sits between the bin-state RAM read port and its write-back/display path.

## Interface
- WORD_WIDTH, 16, width of each real/imag component of samples, twiddles and bin values
- FFT_SIZE, 512, number of bins; index width is IDX_W = $clog2(FFT_SIZE)
- SIDE_WIDTH, 2, opaque sideband bits delayed with the data (e.g. {wr_en, disp_wr_en})
- TW_FRAC, WORD_WIDTH-2, fractional bits of twiddle components (Q2.14 at default)
- SATCNT_WIDTH, 16, width of the saturation counter

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- i_ce  in  1  pipeline enable; low = every register holds
- i_valid  in  1  transaction present this cycle
- i_sample_new  in  WORD_WIDTH  signed newest sample
- i_sample_old  in  WORD_WIDTH  signed sample leaving the window
- i_twiddle  in  2*WORD_WIDTH  {re, im}, signed, TW_FRAC fractional bits
- i_xk_prev  in  2*WORD_WIDTH  {re, im}, signed previous bin value
- i_idx  in  IDX_W  bin index
- i_side  in  SIDE_WIDTH  sideband
- i_bypass  in  1  output Xk_prev + diff without rotation
- i_clr  in  1  output zero for this transaction
- i_sat_clear  in  1  clear the saturation counter
- o_valid  out  1  o_xk / o_idx / o_side valid
- o_xk  out  2*WORD_WIDTH  {re, im} result
- o_idx  out  IDX_W  index aligned with o_xk
- o_side  out  SIDE_WIDTH  sideband aligned with o_xk
- o_sat  out  1  this output was saturated
- o_sat_count  out  SATCNT_WIDTH  saturating count of saturated outputs

## Operation
- Four register stages (S1–S4). All stages advance only when i_ce=1. Mode bits, idx, side and valid travel with the data.
- **S1 (add).** a_re = xk_re + new − old, computed at WORD_WIDTH+2 bits with no wrap. a_im = xk_im, sign-extended.
- **S2 (multiply).** Four signed products of a × twiddle, each 2*WORD_WIDTH+2 bits.
- **S3 (combine).** p_re = ar·tr − ai·ti and p_im = ar·ti + ai·tr, each 2*WORD_WIDTH+3 bits.
- **S4 (round and saturate).**
  - Rounding is round-half-up: add 2^(TW_FRAC−1), then arithmetic shift right by TW_FRAC.
  - Saturate each component to [−2^(W−1), 2^(W−1)−1].
  - o_sat=1 if either component clipped.
- **Bypass mode.** S4 takes the S1 value (carried through the pipeline) with no shift, saturated the same way. Latency is unchanged.
- **Clear mode.** o_xk=0 and o_sat=0. i_clr has priority over i_bypass.
- **Invalid beats.** When i_valid=0 the beat still flows through the pipeline. o_valid=0 for it, and o_sat is forced to 0.
- **Saturation counter.**
  - Increments by 1 on each S4 load with valid=1 and saturation=1.
  - Sticks at all-ones.
  - i_sat_clear has priority; if a clear and an increment coincide, the result is 1.
- **Reset.** o_valid, o_xk, o_idx, o_side, o_sat and o_sat_count are all 0, and all internal valids are 0. In-flight transactions are discarded. Reset overrides i_ce.

## Timing
- Latency is exactly 4 cycles in which i_ce=1, from input sample to output. Throughput is one transaction per ce-high cycle.
- **Stall (i_ce=0).**
  - All stages and outputs hold their values.
  - o_valid can remain high across a stall. A downstream transfer counts only on cycles where o_valid=1 and i_ce=1 (same convention on the input side).
- Order is preserved; no transaction is dropped or duplicated except on reset.
- The counter and i_sat_clear are gated by i_ce exactly like the data path.
- Mode inputs are sampled only with their own transaction and may change every cycle.

## Test plan
- **Identity twiddle.** xk=(100,50), new=30, old=10, tw=(0x4000,0), single valid beat → exactly 4 ce cycles later o_valid=1, o_xk=(120,50), o_sat=0.
- **j twiddle.** Same inputs, tw=(0,0x4000) → o_xk=(−50,120). Back-to-back beats with idx 0..7 emerge consecutively with idx 0..7.
- **Rounding.** tw=(0x2000,0), xk=(3,−3), new=old=0 → o_xk=(2,−1).
- **Saturation.** xk=(32767,0), new=100, old=0, tw=1.0 → o_xk=(32767,0), o_sat=1, o_sat_count=1. Asserting i_sat_clear on the same ce cycle as a second saturated load → count=1.
- **Stall and reset.**
  - Drive 3 beats; drop i_ce for 3 cycles mid-flight → outputs hold, all 3 results appear in order after 4 ce-high cycles total each.
  - reset for 1 cycle mid-flight → next cycle o_valid=0, o_sat_count=0, and no stale beat ever appears.
- **Modes.** i_bypass with xk=(10,−5), new=7, old=2, tw arbitrary → o_xk=(15,−5). i_clr together with i_bypass → o_xk=0, o_sat=0.
